preg_freelist_ctrl: RTL and testbench

//  Physical-register free-list controller for the rename stage of the out-of-order core.
//  - Hands out up to two free physical-register tags per cycle to dispatch.
//  - Reclaims up to two superseded tags per cycle from commit.
//  - Restores the speculative allocation point on a pipeline flush.
//  - Sits between the dispatch/rename logic and the ROB commit port; replaces per-register

---
 rtl/preg_freelist_ctrl.sv | 124 ++++++++++++
 tb/tb_preg_freelist_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/preg_freelist_ctrl.sv
// rtl/preg_freelist_ctrl.sv - physical-register free-list ring for rename
// Ordered tag ring with tail, commit head and speculative head; flush rewinds shead to chead.
module preg_freelist_ctrl #(
  parameter int PREG_W = 7,
  parameter int NPREG  = 128,
  parameter int NARCH  = 64,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        alloc_req,
  output logic              alloc_gnt,
  output logic [PREG_W-1:0] alloc_tag0,
  output logic [PREG_W-1:0] alloc_tag1,
  output logic              alloc_stall,
  input  logic [1:0]        cmt_v,
  input  logic [1:0]        free_v,
  input  logic [PREG_W-1:0] free_tag0,
  input  logic [PREG_W-1:0] free_tag1,
  input  logic              flush,
  output logic [PREG_W-1:0] avail_cnt,
  output logic              init_done,
  output logic              err_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state;
  logic [PW-1:0]     tail, chead, shead;
  logic [PREG_W-1:0] ram [DEPTH];

  logic              run;
  logic [1:0]        n_req, n_cmt, n_free;
  logic [PW-1:0]     live;
  logic [PW:0]       live_after;
  logic              ovf;
  logic [PW-1:0]     tail_next, chead_next, shead_next, avail_next;
  logic [AW-1:0]     t_idx0, t_idx1, s_idx0, s_idx1;
  logic [PREG_W-1:0] init_tag0, init_tag1;

  assign run    = (state == S_RUN);
  assign n_req  = {1'b0, alloc_req[0]} + {1'b0, alloc_req[1]};
  assign n_cmt  = {1'b0, cmt_v[0]} + {1'b0, cmt_v[1]};
  assign n_free = {1'b0, free_v[0]} + {1'b0, free_v[1]};

  assign t_idx0 = tail[AW-1:0];
  assign t_idx1 = tail[AW-1:0] + AW'(1);
  assign s_idx0 = shead[AW-1:0];
  assign s_idx1 = shead[AW-1:0] + AW'(1);

  // Tags handed out at reset are the ones not holding architectural state.
  assign init_tag0 = PREG_W'((NARCH + int'(tail)) % NPREG);
  assign init_tag1 = PREG_W'((NARCH + int'(tail) + 1) % NPREG);

  assign live       = tail - chead;
  assign live_after = {1'b0, live} + (PW+1)'(n_free);
  assign ovf        = run && (n_free != 2'd0) && (live_after > (PW+1)'(DEPTH));

  assign alloc_gnt   = run && (n_req != 2'd0) && (avail_cnt >= PREG_W'(n_req)) && !flush;
  assign alloc_stall = run && (alloc_req != 2'b00) && !alloc_gnt;
  assign alloc_tag0  = run ? ram[s_idx0] : '0;
  assign alloc_tag1  = run ? ram[s_idx1] : '0;
  assign init_done   = run;

  always_comb begin
    chead_next = chead;
    shead_next = shead;
    tail_next  = tail;
    if (!run) begin
      tail_next = tail + PW'(2);
    end else begin
      chead_next = chead + PW'(n_cmt);
      if (!ovf)
        tail_next = tail + PW'(n_free);
      if (flush)
        shead_next = chead_next;
      else if (alloc_gnt)
        shead_next = shead + PW'(n_req);
    end
    avail_next = tail_next - shead_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      tail      <= '0;
      chead     <= '0;
      shead     <= '0;
      avail_cnt <= '0;
      err_ovf   <= 1'b0;
    end else begin
      tail      <= tail_next;
      chead     <= chead_next;
      shead     <= shead_next;
      avail_cnt <= PREG_W'(avail_next);
      if (ovf)
        err_ovf <= 1'b1;
      if (!run && tail == PW'(DEPTH - 2))
        state <= S_RUN;
    end
  end

  // Ring storage has no reset; INIT overwrites every entry before RUN.
  always_ff @(posedge clk) begin
    if (!run) begin
      ram[t_idx0] <= init_tag0;
      ram[t_idx1] <= init_tag1;
    end else if (!ovf) begin
      case (free_v)
        2'b01: ram[t_idx0] <= free_tag0;
        2'b10: ram[t_idx0] <= free_tag1;
        2'b11: begin
          ram[t_idx0] <= free_tag0;
          ram[t_idx1] <= free_tag1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_preg_freelist_ctrl.sv
// tb/tb_preg_freelist_ctrl.sv - directed bench for preg_freelist_ctrl
module tb_preg_freelist_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] alloc_req;
  logic       alloc_gnt;
  logic [6:0] alloc_tag0, alloc_tag1;
  logic       alloc_stall;
  logic [1:0] cmt_v, free_v;
  logic [6:0] free_tag0, free_tag1;
  logic       flush;
  logic [6:0] avail_cnt;
  logic       init_done;
  logic       err_ovf;

  int tests = 0;
  int fails = 0;
  logic       g, st;
  logic [6:0] tg0, tg1;

  preg_freelist_ctrl dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1), .alloc_stall(alloc_stall),
    .cmt_v(cmt_v), .free_v(free_v), .free_tag0(free_tag0), .free_tag1(free_tag1),
    .flush(flush), .avail_cnt(avail_cnt), .init_done(init_done), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive one cycle, capture combinational outputs, return at next negedge.
  task automatic cyc(input logic [1:0] req, input logic [1:0] cmt, input logic [1:0] fv,
                     input logic [6:0] t0, input logic [6:0] t1, input logic fl);
    alloc_req = req; cmt_v = cmt; free_v = fv; free_tag0 = t0; free_tag1 = t1; flush = fl;
    #1;
    g = alloc_gnt; st = alloc_stall; tg0 = alloc_tag0; tg1 = alloc_tag1;
    @(negedge clk);
    alloc_req = 2'b00; cmt_v = 2'b00; free_v = 2'b00; free_tag0 = '0; free_tag1 = '0; flush = 1'b0;
  endtask

  task automatic wait_init();
    for (int i = 0; i < 40 && !init_done; i++) @(negedge clk);
    chk("init_done", init_done, 1);
    chk("init_avail", avail_cnt, 64);
    chk("init_err", err_ovf, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    clk = 0; rst = 0;
    alloc_req = 0; cmt_v = 0; free_v = 0; free_tag0 = 0; free_tag1 = 0; flush = 0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", alloc_gnt, 0);
    chk("rst_stall", alloc_stall, 0);
    chk("rst_avail", avail_cnt, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_err", err_ovf, 0);
    chk("rst_tag0", alloc_tag0, 0);
    rst = 1;
    wait_init();

    // 1: first dual allocation
    cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
    chk("t1_gnt", g, 1);
    chk("t1_tag0", tg0, 64);
    chk("t1_tag1", tg1, 65);
    chk("t1_avail", avail_cnt, 62);

    // 2: exhaust, then bring avail to exactly one via a slot1-only free
    for (int i = 0; i < 31; i++) begin
      cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
      chk("t2_gnt", g, 1);
      chk("t2_tag0", tg0, 66 + 2 * i);
      chk("t2_tag1", tg1, 67 + 2 * i);
    end
    chk("t2_avail0", avail_cnt, 0);
    cyc(2'b01, 2'b00, 2'b00, 0, 0, 0);
    chk("t2_empty_gnt", g, 0);
    chk("t2_empty_stall", st, 1);
    cyc(2'b00, 2'b11, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b10, 55, 100, 0);
    chk("t2_avail1", avail_cnt, 1);
    cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
    chk("t2_one_dual_gnt", g, 0);
    chk("t2_one_dual_stall", st, 1);
    cyc(2'b01, 2'b00, 2'b00, 0, 0, 0);
    chk("t2_one_single_gnt", g, 1);
    chk("t2_one_single_tag", tg0, 100);
    chk("t2_avail_after", avail_cnt, 0);

    // 3: dual free after exhaustion, reallocated across the ring wrap
    cyc(2'b00, 2'b11, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b11, 70, 5, 0);
    chk("t3_avail2", avail_cnt, 2);
    chk("t3_err", err_ovf, 0);
    cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
    chk("t3_gnt", g, 1);
    chk("t3_tag0", tg0, 70);
    chk("t3_tag1", tg1, 5);
    chk("t3_avail0", avail_cnt, 0);

    // 4: flush rewinds speculative head to commit head
    do_reset();
    wait_init();
    cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
    cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
    cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
    chk("t4_tag0", tg0, 68);
    chk("t4_tag1", tg1, 69);
    cyc(2'b00, 2'b01, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b01, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 1);
    chk("t4_avail", avail_cnt, 62);
    cyc(2'b01, 2'b00, 2'b00, 0, 0, 0);
    chk("t4_gnt", g, 1);
    chk("t4_retag", tg0, 66);
    cyc(2'b10, 2'b00, 2'b00, 0, 0, 0);
    chk("t4_slot1_only", tg0, 67);
    cyc(2'b01, 2'b00, 2'b00, 0, 0, 0);
    chk("t4_avail59", avail_cnt, 59);

    // 5: flush with same-cycle request, commit and free
    cyc(2'b11, 2'b11, 2'b01, 9, 0, 1);
    chk("t5_gnt", g, 0);
    chk("t5_avail", avail_cnt, 61);
    for (int i = 0; i < 30; i++) begin
      cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
      chk("t5_tag0", tg0, 68 + 2 * i);
    end
    chk("t5_avail1", avail_cnt, 1);
    cyc(2'b01, 2'b00, 2'b00, 0, 0, 0);
    chk("t5_freed_gnt", g, 1);
    chk("t5_freed_tag", tg0, 9);
    chk("t5_avail0", avail_cnt, 0);

    // 6: overflow on a full ring, then asynchronous reset mid-RUN
    do_reset();
    wait_init();
    cyc(2'b00, 2'b00, 2'b01, 3, 0, 0);
    chk("t6_err", err_ovf, 1);
    chk("t6_avail", avail_cnt, 64);
    cyc(2'b00, 2'b00, 2'b00, 0, 0, 0);
    chk("t6_err_sticky", err_ovf, 1);
    cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
    chk("t6_tag0_kept", tg0, 64);
    chk("t6_tag1_kept", tg1, 65);
    @(posedge clk);
    #2;
    rst = 0;
    alloc_req = 2'b11;
    #1;
    chk("t6_arst_gnt", alloc_gnt, 0);
    chk("t6_arst_stall", alloc_stall, 0);
    chk("t6_arst_done", init_done, 0);
    chk("t6_arst_avail", avail_cnt, 0);
    chk("t6_arst_err", err_ovf, 0);
    chk("t6_arst_tag0", alloc_tag0, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    #1;
    chk("t6_init_ignore_gnt", alloc_gnt, 0);
    chk("t6_init_ignore_stall", alloc_stall, 0);
    alloc_req = 2'b00;
    wait_init();
    cyc(2'b11, 2'b00, 2'b00, 0, 0, 0);
    chk("t6_rerun_tag0", tg0, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
